// File: rtl/uart_seq_ctrl_pkg.sv
// Shared constants and types for the UART register sequencer.
package uart_seq_ctrl_pkg;

  // UART register word addresses (byte address bits [11:2])
  localparam logic [9:0]  UART_DATA = 10'd0;
  localparam logic [9:0]  UART_MODE = 10'd2;
  localparam logic [9:0]  UART_BAUD = 10'd4;

  // Mode register encodings
  localparam logic [31:0] MODE_TX = 32'd1;
  localparam logic [31:0] MODE_RX = 32'd2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_ACCESS     = 3'd2,
    ST_GAP        = 3'd3,
    ST_WAIT_FRAME = 3'd4,
    ST_RESP       = 3'd5
  } state_t;

  // Which register transaction the bus phases are currently carrying
  typedef enum logic [1:0] {
    STEP_BAUD = 2'd0,
    STEP_MODE = 2'd1,
    STEP_DATA = 2'd2,
    STEP_READ = 2'd3
  } step_t;

endpackage

// File: rtl/uart_seq_ctrl_frame_timer.sv
// Frame wait timer: loads baud*FRAME_BITS+GUARD and counts down while running.
// o_done is high in the last of the loaded number of run cycles.
module uart_seq_ctrl_frame_timer #(
  parameter int BAUD_W     = 16,
  parameter int FRAME_BITS = 10,
  parameter int GUARD      = 20
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [BAUD_W-1:0] i_baud,
  input  logic              i_run,
  output logic              o_done
);

  localparam int CNT_W = BAUD_W + 5;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_total;

  // Baud is never zero here (rejected at accept), so total-1 cannot wrap
  assign w_total = CNT_W'(i_baud) * CNT_W'(FRAME_BITS) + CNT_W'(GUARD);
  assign o_done  = i_run && (r_cnt == '0);

  // Down-counter with terminal-count compare
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= w_total - CNT_W'(1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_seq_ctrl.sv
// Bus-master sequencer for one UART: turns byte TX/RX commands into
// baud/mode/data register writes (skipping cached config) and a data read-back.
//
// state      | meaning
// IDLE       | cmd_ready high, waiting for a command
// SETUP      | sel=1 en=0, address/data presented for current step
// ACCESS     | sel=1 en=1, waiting for p_ready (bounded by BUS_TIMEOUT)
// GAP        | one idle bus cycle, then next step or frame wait
// WAIT_FRAME | wait baud*FRAME_BITS+GUARD cycles for the frame to finish
// RESP       | one-cycle rsp_valid, cache update, back to IDLE
module uart_seq_ctrl
  import uart_seq_ctrl_pkg::*;
#(
  parameter int BAUD_W      = 16,
  parameter int FRAME_BITS  = 10,
  parameter int GUARD       = 20,
  parameter int BUS_TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_rx,
  input  logic [BAUD_W-1:0] i_cmd_baud,
  input  logic [7:0]        i_cmd_byte,
  output logic              o_rsp_valid,
  output logic [7:0]        o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_busy,
  output logic              o_p_sel,
  output logic              o_p_enable,
  output logic [9:0]        o_p_addr,
  output logic [31:0]       o_p_wdata,
  input  logic [31:0]       i_p_rdata,
  input  logic              i_p_ready
);

  localparam int TO_W = $clog2(BUS_TIMEOUT + 1);

  state_t            r_state, w_state_nxt;
  step_t             r_step, w_step_nxt;
  logic              r_rx;
  logic [BAUD_W-1:0] r_baud;
  logic [7:0]        r_byte;
  logic              r_need_mode;
  logic              r_err;
  logic [7:0]        r_rdata;
  logic              r_cache_vld;
  logic              r_cache_rx;
  logic [BAUD_W-1:0] r_cache_baud;
  logic [TO_W-1:0]   r_to_cnt;

  logic w_need_baud, w_need_mode;
  logic w_accept, w_timeout, w_timer_load, w_rd_cap, w_frame_done;
  logic w_unused_rdata;

  assign w_unused_rdata = ^i_p_rdata[31:8];
  assign w_need_baud    = !r_cache_vld || (i_cmd_baud != r_cache_baud);
  assign w_need_mode    = !r_cache_vld || (i_cmd_rx != r_cache_rx);

  uart_seq_ctrl_frame_timer #(
    .BAUD_W     (BAUD_W),
    .FRAME_BITS (FRAME_BITS),
    .GUARD      (GUARD)
  ) u_frame_timer (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_timer_load),
    .i_baud  (r_baud),
    .i_run   (r_state == ST_WAIT_FRAME),
    .o_done  (w_frame_done)
  );

  // State and step registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= STEP_BAUD;
    end else begin
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
    end
  end

  // Next-state logic and single-cycle control strobes
  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step;
    w_accept     = 1'b0;
    w_timeout    = 1'b0;
    w_timer_load = 1'b0;
    w_rd_cap     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          w_accept = 1'b1;
          if (i_cmd_baud == '0) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_SETUP;
            w_step_nxt  = w_need_baud ? STEP_BAUD : (w_need_mode ? STEP_MODE : STEP_DATA);
          end
        end
      end
      ST_SETUP: w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (i_p_ready) begin
          w_state_nxt = ST_GAP;
          w_rd_cap    = (r_step == STEP_READ);
        end else if (r_to_cnt == '0) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_GAP: begin
        case (r_step)
          STEP_BAUD: begin
            w_step_nxt  = r_need_mode ? STEP_MODE : STEP_DATA;
            w_state_nxt = ST_SETUP;
          end
          STEP_MODE: begin
            w_step_nxt  = STEP_DATA;
            w_state_nxt = ST_SETUP;
          end
          STEP_DATA: begin
            w_timer_load = 1'b1;
            w_state_nxt  = ST_WAIT_FRAME;
          end
          default: w_state_nxt = ST_RESP;
        endcase
      end
      ST_WAIT_FRAME: begin
        if (w_frame_done) begin
          if (r_rx) begin
            w_step_nxt  = STEP_READ;
            w_state_nxt = ST_SETUP;
          end else begin
            w_state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from state and step; bus fields are zero outside SETUP/ACCESS
  always_comb begin
    o_cmd_ready = (r_state == ST_IDLE);
    o_busy      = (r_state != ST_IDLE);
    o_p_sel     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    o_p_enable  = (r_state == ST_ACCESS);
    o_rsp_valid = (r_state == ST_RESP);
    o_rsp_err   = (r_state == ST_RESP) && r_err;
    o_rsp_data  = (r_state == ST_RESP) ? r_rdata : 8'd0;
    o_p_addr    = '0;
    o_p_wdata   = '0;
    if (o_p_sel) begin
      case (r_step)
        STEP_BAUD: begin
          o_p_addr  = UART_BAUD;
          o_p_wdata = 32'(r_baud);
        end
        STEP_MODE: begin
          o_p_addr  = UART_MODE;
          o_p_wdata = r_rx ? MODE_RX : MODE_TX;
        end
        STEP_DATA: begin
          o_p_addr  = UART_DATA;
          o_p_wdata = r_rx ? 32'd0 : {24'd0, r_byte};
        end
        default: begin
          o_p_addr  = UART_DATA;
          o_p_wdata = 32'd0;
        end
      endcase
    end
  end

  // Command latch, access timeout, read capture and config cache
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx         <= 1'b0;
      r_baud       <= '0;
      r_byte       <= '0;
      r_need_mode  <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_cache_vld  <= 1'b0;
      r_cache_rx   <= 1'b0;
      r_cache_baud <= '0;
      r_to_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_rx        <= i_cmd_rx;
        r_baud      <= i_cmd_baud;
        r_byte      <= i_cmd_byte;
        r_need_mode <= w_need_mode;
        r_err       <= (i_cmd_baud == '0);
        r_rdata     <= '0;
      end
      if (r_state == ST_SETUP) begin
        r_to_cnt <= TO_W'(BUS_TIMEOUT - 1);
      end else if ((r_state == ST_ACCESS) && (r_to_cnt != '0)) begin
        r_to_cnt <= r_to_cnt - TO_W'(1);
      end
      if (w_rd_cap) begin
        r_rdata <= i_p_rdata[7:0];
      end
      // A timed-out access leaves the UART config unknown
      if (w_timeout) begin
        r_err       <= 1'b1;
        r_cache_vld <= 1'b0;
      end
      if ((r_state == ST_RESP) && !r_err) begin
        r_cache_vld  <= 1'b1;
        r_cache_baud <= r_baud;
        r_cache_rx   <= r_rx;
      end
    end
  end

endmodule

// File: tb/tb_uart_seq_ctrl.sv
// Directed bench for uart_seq_ctrl with a behavioural UART slave.
module tb_uart_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_rx;
  logic [15:0] cmd_baud;
  logic [7:0]  cmd_byte;
  logic        rsp_valid, rsp_err, busy;
  logic [7:0]  rsp_data;
  logic        p_sel, p_enable, p_ready;
  logic [9:0]  p_addr;
  logic [31:0] p_wdata, p_rdata;

  always #5 clk = ~clk;

  uart_seq_ctrl #(
    .BAUD_W(16), .FRAME_BITS(10), .GUARD(20), .BUS_TIMEOUT(64)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_rx(cmd_rx),
    .i_cmd_baud(cmd_baud), .i_cmd_byte(cmd_byte),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy),
    .o_p_sel(p_sel), .o_p_enable(p_enable), .o_p_addr(p_addr), .o_p_wdata(p_wdata),
    .i_p_rdata(p_rdata), .i_p_ready(p_ready)
  );

  typedef struct packed {
    logic              rx;
    logic [15:0]       baud;
    logic [7:0]        byt;
    logic [7:0]        peer;
    logic [7:0]        stall;   // 0: ready always high, FF: never ready, n: ready on ACCESS cycle n+1
    logic              poke;    // pulse cmd_valid while busy
    logic [2:0]        n_tr;
    logic [3:0][9:0]   ex_addr;
    logic [3:0][31:0]  ex_wd;
    logic              ex_err;
    logic [7:0]        ex_data;
    logic [15:0]       ex_run;  // longest busy bus-idle run (GAP + frame wait)
    logic [15:0]       ex_acc;  // longest ACCESS run
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  // Shared between slave/monitor (writer) and stimulus (reader)
  int          cyc_cnt = 0;
  int          tr_n = 0;
  logic [9:0]  tr_addr [256];
  logic [31:0] tr_wd   [256];
  int          prot_err = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  logic        rsp_err_s = 1'b0;
  logic [7:0]  rsp_data_s = 8'd0;
  int          max_acc = 0, max_run = 0;
  int          acc_seen = 0, idle_run = 0, seen_id = 0;
  logic [9:0]  set_addr = '0;
  logic [31:0] set_wd = '0;
  // Written by stimulus only
  int          run_id = 0;
  logic [7:0]  cur_stall = 8'd0;
  logic [7:0]  peer_data = 8'd0;

  assign p_rdata = {24'h5A5A5A, peer_data};

  // Slave model and bus monitor
  always @(negedge clk) begin
    cyc_cnt++;
    if (run_id != seen_id) begin
      seen_id = run_id;
      max_acc = 0;
      max_run = 0;
    end
    if (p_sel && p_enable) acc_seen++; else acc_seen = 0;
    if (acc_seen > max_acc) max_acc = acc_seen;
    if (cur_stall == 8'h00)      p_ready = 1'b1;
    else if (cur_stall == 8'hFF) p_ready = 1'b0;
    else                         p_ready = p_sel && p_enable && (acc_seen > int'(cur_stall));
    if (p_sel && !p_enable) begin
      tr_addr[tr_n % 256] = p_addr;
      tr_wd[tr_n % 256]   = p_wdata;
      tr_n++;
      set_addr = p_addr;
      set_wd   = p_wdata;
    end
    if (p_sel && p_enable && (p_addr != set_addr || p_wdata != set_wd)) prot_err++;
    if (!p_sel && (p_enable || p_addr != 10'd0 || p_wdata != 32'd0)) prot_err++;
    if (busy && !p_sel && !rsp_valid) idle_run++; else idle_run = 0;
    if (idle_run > max_run) max_run = idle_run;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc    = cyc_cnt;
      rsp_err_s  = rsp_err;
      rsp_data_s = rsp_data;
    end
    if (!rsp_valid && (rsp_err || rsp_data != 8'd0)) prot_err++;
    if (cmd_ready == busy) prot_err++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mk(input logic rx, input logic [15:0] baud, input logic [7:0] byt,
                              input logic [7:0] peer, input logic [7:0] stall, input logic poke,
                              input logic [2:0] n_tr,
                              input logic [9:0] a0, input logic [31:0] w0,
                              input logic [9:0] a1, input logic [31:0] w1,
                              input logic [9:0] a2, input logic [31:0] w2,
                              input logic [9:0] a3, input logic [31:0] w3,
                              input logic err, input logic [7:0] data,
                              input logic [15:0] run, input logic [15:0] acc);
    vec_t v;
    v.rx = rx; v.baud = baud; v.byt = byt; v.peer = peer; v.stall = stall; v.poke = poke;
    v.n_tr = n_tr;
    v.ex_addr[0] = a0; v.ex_wd[0] = w0;
    v.ex_addr[1] = a1; v.ex_wd[1] = w1;
    v.ex_addr[2] = a2; v.ex_wd[2] = w2;
    v.ex_addr[3] = a3; v.ex_wd[3] = w3;
    v.ex_err = err; v.ex_data = data; v.ex_run = run; v.ex_acc = acc;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int base_tr, base_rsp, base_prot, acc_cyc, cyc;
    @(negedge clk); #2;
    run_id++;
    base_tr   = tr_n;
    base_rsp  = rsp_cnt;
    base_prot = prot_err;
    check($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd1);
    cur_stall = v.stall;
    peer_data = v.peer;
    cmd_valid = 1'b1;
    cmd_rx    = v.rx;
    cmd_baud  = v.baud;
    cmd_byte  = v.byt;
    @(posedge clk);
    acc_cyc = cyc_cnt;
    #1 cmd_valid = 1'b0;
    cmd_byte = 8'h00;
    if (v.poke) begin
      repeat (3) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_byte  = 8'hEE;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      cmd_byte  = 8'h00;
    end
    cyc = 0;
    while (rsp_cnt == base_rsp && cyc < 5000) begin
      @(negedge clk); #2;
      cyc++;
    end
    if (rsp_cnt == base_rsp) begin
      n_cmp++;
      n_err++;
      $display("FAIL v%0d_rsp_timeout: no rsp_valid within %0d cycles", idx, cyc);
    end
    repeat (4) @(negedge clk);
    #2;
    check($sformatf("v%0d_rsp_count", idx), 32'(rsp_cnt - base_rsp), 32'd1);
    check($sformatf("v%0d_n_tr", idx), 32'(tr_n - base_tr), 32'(v.n_tr));
    for (int i = 0; i < 4; i++) begin
      if (i < int'(v.n_tr)) begin
        check($sformatf("v%0d_tr%0d_addr", idx, i), 32'(tr_addr[(base_tr + i) % 256]), 32'(v.ex_addr[i]));
        check($sformatf("v%0d_tr%0d_wdata", idx, i), tr_wd[(base_tr + i) % 256], v.ex_wd[i]);
      end
    end
    check($sformatf("v%0d_rsp_err", idx), 32'(rsp_err_s), 32'(v.ex_err));
    check($sformatf("v%0d_rsp_data", idx), 32'(rsp_data_s), 32'(v.ex_data));
    check($sformatf("v%0d_wait_run", idx), 32'(max_run), 32'(v.ex_run));
    check($sformatf("v%0d_access_run", idx), 32'(max_acc), 32'(v.ex_acc));
    check($sformatf("v%0d_protocol", idx), 32'(prot_err - base_prot), 32'd0);
    if (v.baud == 16'd0)
      check($sformatf("v%0d_baud0_latency", idx), 32'(rsp_cyc - acc_cyc), 32'd1);
  endtask

  vec_t vecs [9];

  initial begin
    int cyc, base_tr, base_rsp;
    vecs[0] = mk(0, 16'd20, 8'd101, 8'd0, 8'd0, 0, 3, 10'd4, 32'd20, 10'd2, 32'd1, 10'd0, 32'd101, 10'd0, 32'd0, 0, 8'd0, 16'd221, 16'd1);
    vecs[1] = mk(0, 16'd20, 8'd55, 8'd0, 8'd2, 1, 1, 10'd0, 32'd55, 10'd0, 32'd0, 10'd0, 32'd0, 10'd0, 32'd0, 0, 8'd0, 16'd221, 16'd3);
    vecs[2] = mk(1, 16'd40, 8'h5F, 8'd64, 8'd1, 0, 4, 10'd4, 32'd40, 10'd2, 32'd2, 10'd0, 32'd0, 10'd0, 32'd0, 0, 8'd64, 16'd421, 16'd2);
    vecs[3] = mk(0, 16'd30, 8'hAA, 8'd0, 8'hFF, 0, 1, 10'd4, 32'd30, 10'd0, 32'd0, 10'd0, 32'd0, 10'd0, 32'd0, 1, 8'd0, 16'd0, 16'd64);
    vecs[4] = mk(0, 16'd30, 8'h3C, 8'd0, 8'd1, 0, 3, 10'd4, 32'd30, 10'd2, 32'd1, 10'd0, 32'h3C, 10'd0, 32'd0, 0, 8'd0, 16'd321, 16'd2);
    vecs[5] = mk(0, 16'd0, 8'h99, 8'd0, 8'd0, 0, 0, 10'd0, 32'd0, 10'd0, 32'd0, 10'd0, 32'd0, 10'd0, 32'd0, 1, 8'd0, 16'd0, 16'd0);
    vecs[6] = mk(0, 16'd30, 8'h11, 8'd0, 8'd0, 0, 1, 10'd0, 32'h11, 10'd0, 32'd0, 10'd0, 32'd0, 10'd0, 32'd0, 0, 8'd0, 16'd321, 16'd1);
    vecs[7] = mk(1, 16'd30, 8'h00, 8'hC3, 8'd0, 0, 3, 10'd2, 32'd2, 10'd0, 32'd0, 10'd0, 32'd0, 10'd0, 32'd0, 0, 8'hC3, 16'd321, 16'd1);
    vecs[8] = mk(0, 16'd20, 8'h77, 8'd0, 8'd0, 0, 3, 10'd4, 32'd20, 10'd2, 32'd1, 10'd0, 32'h77, 10'd0, 32'd0, 0, 8'd0, 16'd221, 16'd1);

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_rx = 1'b0; cmd_baud = 16'd0; cmd_byte = 8'd0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_p_sel_en", 32'({p_sel, p_enable}), 32'd0);
    check("rst_p_addr", 32'(p_addr), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset while waiting for the frame: command is lost, cache invalidated
    @(negedge clk); #2;
    run_id++;
    base_tr  = tr_n;
    base_rsp = rsp_cnt;
    cur_stall = 8'd0;
    cmd_valid = 1'b1; cmd_rx = 1'b0; cmd_baud = 16'd20; cmd_byte = 8'h77;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (!((tr_n - base_tr) == 3 && !p_sel) && cyc < 500) begin
      @(negedge clk); #2;
      cyc++;
    end
    check("rstmid_tr_issued", 32'(tr_n - base_tr), 32'd3);
    repeat (50) @(negedge clk);
    #2;
    check("rstmid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_bus", 32'({p_sel, p_enable, rsp_valid, rsp_err}), 32'd0);
    check("rstmid_wdata", p_wdata, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk); #2;
    check("rstmid_ready_after", 32'(cmd_ready), 32'd1);
    check("rstmid_no_rsp", 32'(rsp_cnt - base_rsp), 32'd0);
    run_vec(8, vecs[8]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
